// File: rtl/lift_din_buff.sv
// Ping-pong input staging buffer for the lift core: rows of 8 x 30-bit lane
// words are written wide, then streamed one word at a time in lane-major order.
module lift_din_buff (
   input  logic         clk,
   input  logic         rst,
   input  logic         mode,
   input  logic         wr_en,
   input  logic [2:0]   wr_addr,
   input  logic [239:0] din,
   output logic         wr_ready,
   output logic [29:0]  dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic [2:0]   rd_lane,
   output logic [2:0]   rd_word,
   output logic         last_word,
   output logic         eight_lift_input_read_done
);

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_t;

   state_t       r_state;
   logic [239:0] r_mem [0:13];
   logic [1:0]   r_full;
   logic         r_wt_sel;
   logic         r_rd_sel;
   logic [2:0]   r_lane;
   logic [2:0]   r_word;
   logic         r_done;

   logic [2:0]   w_last_row;
   logic         w_wr_fire;
   logic         w_wr_last;
   logic         w_xfer;
   logic         w_batch_end;
   logic [1:0]   w_full_set;
   logic [1:0]   w_full_clr;
   logic [3:0]   w_wr_idx;
   logic [3:0]   w_rd_idx;
   logic [239:0] w_rd_row;
   logic [29:0]  w_lane_word;

   assign w_last_row  = mode ? 3'd5 : 3'd6;
   assign wr_ready    = ~r_full[r_wt_sel];
   assign w_wr_fire   = wr_en & wr_ready;
   assign w_wr_last   = w_wr_fire & (wr_addr == w_last_row);
   assign dout_valid  = (r_state == ST_STREAM);
   assign w_xfer      = dout_valid & dout_ready;
   assign last_word   = dout_valid & (r_word == w_last_row);
   assign w_batch_end = w_xfer & last_word & (r_lane == 3'd7);

   // Half h occupies rows 7h..7h+6 of the storage array.
   assign w_wr_idx = r_wt_sel ? (4'd7 + {1'b0, wr_addr}) : {1'b0, wr_addr};
   assign w_rd_idx = r_rd_sel ? (4'd7 + {1'b0, r_word})  : {1'b0, r_word};

   assign w_full_set = w_wr_last   ? (r_wt_sel ? 2'b10 : 2'b01) : 2'b00;
   assign w_full_clr = w_batch_end ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk) begin
      if (w_wr_fire && (wr_addr <= 3'd6))
         r_mem[w_wr_idx] <= din;
   end

   // The half being read is full, so it never sees a write while streaming.
   always_comb begin
      w_rd_row    = r_mem[w_rd_idx];
      w_lane_word = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (r_lane == k[2:0])
            w_lane_word = w_rd_row[30*k +: 30];
      end
   end

   assign dout                       = dout_valid ? w_lane_word : '0;
   assign rd_lane                    = r_lane;
   assign rd_word                    = r_word;
   assign eight_lift_input_read_done = r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_full   <= '0;
         r_wt_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_lane   <= '0;
         r_word   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_batch_end;
         // Set and clear always target different halves, so both apply.
         r_full <= (r_full | w_full_set) & ~w_full_clr;
         if (w_wr_last)
            r_wt_sel <= ~r_wt_sel;

         case (r_state)
            ST_IDLE: begin
               r_lane <= '0;
               r_word <= '0;
               if (r_full[r_rd_sel])
                  r_state <= ST_STREAM;
            end
            ST_STREAM: begin
               if (w_xfer) begin
                  if (last_word) begin
                     r_word <= '0;
                     r_lane <= r_lane + 3'd1;
                     if (r_lane == 3'd7) begin
                        r_state  <= ST_IDLE;
                        r_rd_sel <= ~r_rd_sel;
                     end
                  end else begin
                     r_word <= r_word + 3'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lift_din_buff.sv
// Randomised self-checking bench for lift_din_buff against a batch-level
// reference model (linear word position within a batch, lane = pos / rows).
module tb_lift_din_buff;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         mode = 1'b0;
   logic         wr_en = 1'b0;
   logic [2:0]   wr_addr = '0;
   logic [239:0] din = '0;
   logic         dout_ready = 1'b0;
   logic         wr_ready;
   logic [29:0]  dout;
   logic         dout_valid;
   logic [2:0]   rd_lane;
   logic [2:0]   rd_word;
   logic         last_word;
   logic         done;

   lift_din_buff dut (
      .clk                        (clk),
      .rst                        (rst),
      .mode                       (mode),
      .wr_en                      (wr_en),
      .wr_addr                    (wr_addr),
      .din                        (din),
      .wr_ready                   (wr_ready),
      .dout                       (dout),
      .dout_valid                 (dout_valid),
      .dout_ready                 (dout_ready),
      .rd_lane                    (rd_lane),
      .rd_word                    (rd_word),
      .last_word                  (last_word),
      .eight_lift_input_read_done (done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   // Reference model state.
   logic [29:0] mmem [2][7][8];
   bit [1:0]    mfull = '0;
   bit          mwt = 1'b0;
   bit          mrd = 1'b0;
   bit          mstream = 1'b0;
   int unsigned mpos = 0;
   bit          mdone = 1'b0;
   int unsigned m_rows;
   bit [1:0]    m_nfull;
   bit          m_nwt;

   logic [29:0] q_out[$];
   int          done_cnt = 0;
   int          rdy_mode = 0;
   int unsigned pc = 0;
   logic [239:0] b1 [7];
   logic [239:0] b2 [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: expected event did not occur within cycle budget (t=%0t)", nm, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic write_row(input logic [2:0] a, input logic [239:0] d);
      wr_en = 1'b1; wr_addr = a; din = d;
      tick();
      wr_en = 1'b0;
   endtask

   function automatic logic [239:0] pat_row(input int unsigned r);
      logic [239:0] v;
      for (int k = 0; k < 8; k++) v[30*k +: 30] = 30'(100*r + k);
      return v;
   endfunction

   function automatic logic [239:0] rand_row();
      logic [239:0] v;
      for (int k = 0; k < 8; k++) v[30*k +: 30] = 30'($urandom);
      return v;
   endfunction

   task automatic wait_idle(input int unsigned budget, input string nm);
      int unsigned c = 0;
      while (!(mstream == 1'b0 && mfull == 2'b00 && !dout_valid) && c < budget) begin
         tick();
         c++;
      end
      if (c >= budget) timeout(nm);
      tick();
   endtask

   task automatic wait_final_word(input string nm);
      int unsigned c = 0;
      while (!(rd_lane == 3'd7 && last_word) && c < 300) begin
         tick();
         c++;
      end
      if (c >= 300) timeout(nm);
   endtask

   // Model update: decisions use pre-edge state; full set/clear merge at the end.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mfull = '0; mwt = 1'b0; mrd = 1'b0; mstream = 1'b0; mpos = 0; mdone = 1'b0;
      end else begin
         m_rows  = mode ? 6 : 7;
         m_nfull = mfull;
         m_nwt   = mwt;
         mdone   = 1'b0;
         if (wr_en && !mfull[mwt]) begin
            if (wr_addr <= 3'd6)
               for (int k = 0; k < 8; k++) mmem[mwt][wr_addr][k] = din[30*k +: 30];
            if (wr_addr == 3'(m_rows - 1)) begin
               m_nfull[mwt] = 1'b1;
               m_nwt = ~mwt;
            end
         end
         if (!mstream) begin
            if (mfull[mrd]) begin
               mstream = 1'b1;
               mpos = 0;
            end
         end else if (dout_ready) begin
            if (mpos == 8*m_rows - 1) begin
               mstream = 1'b0;
               m_nfull[mrd] = 1'b0;
               mrd = ~mrd;
               mdone = 1'b1;
               mpos = 0;
            end else begin
               mpos++;
            end
         end
         mfull = m_nfull;
         mwt = m_nwt;
      end
   end

   int unsigned c_rows, c_lane, c_word;
   logic [29:0] c_dout;

   always @(negedge clk) begin
      if (mon_en) begin
         c_rows = mode ? 6 : 7;
         c_lane = mstream ? mpos / c_rows : 0;
         c_word = mstream ? mpos % c_rows : 0;
         c_dout = mstream ? mmem[mrd][c_word][c_lane] : '0;
         chk("dout_valid", dout_valid, mstream);
         chk("dout", dout, c_dout);
         chk("rd_lane", rd_lane, c_lane);
         chk("rd_word", rd_word, c_word);
         chk("last_word", last_word, (mstream && c_word == c_rows - 1));
         chk("done_pulse", done, mdone);
         chk("wr_ready", wr_ready, !mfull[mwt]);
         if (dout_valid && dout_ready) q_out.push_back(dout);
         if (done) done_cnt++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         pc++;
         case (rdy_mode)
            0: dout_ready = 1'b1;
            1: dout_ready = (pc % 4 == 0) || (pc % 4 == 3);
            2: dout_ready = 1'($urandom_range(0, 1));
            default: dout_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int errs;
      int ord[7];
      int unsigned c;

      // Reset state
      tick();
      mon_en = 1'b1;
      tick();
      chk("rst_wr_ready", wr_ready, 1'b1);
      chk("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_rd_lane", rd_lane, 3'd0);
      chk("rst_done", done, 1'b0);
      rst = 1'b1;
      tick();

      // Mode 0 single batch, patterned data
      mode = 1'b0; rdy_mode = 0;
      q_out.delete(); done_cnt = 0;
      for (int r = 0; r < 7; r++) write_row(3'(r), pat_row(r));
      chk("t1_valid_after_wr_edge", dout_valid, 1'b0);
      tick();
      chk("t1_valid_second_edge", dout_valid, 1'b1);
      chk("t1_first_dout", dout, 30'd0);
      wait_idle(200, "t1_idle");
      chk("t1_count", q_out.size(), 56);
      chk("t1_done_cnt", done_cnt, 1);
      if (q_out.size() == 56) begin
         chk("t1_w1", q_out[1], 30'd100);
         chk("t1_w7", q_out[7], 30'd1);
         chk("t1_w55", q_out[55], 30'd607);
         errs = 0;
         for (int i = 0; i < 56; i++)
            if (q_out[i] !== 30'(100*(i % 7) + i / 7)) errs++;
         chk("t1_seq_errors", errs, 0);
      end

      // Mode 1 with 1,0,0,1 backpressure
      mode = 1'b1; rdy_mode = 1;
      q_out.delete(); done_cnt = 0;
      for (int r = 0; r < 6; r++) begin
         b1[r] = rand_row();
         write_row(3'(r), b1[r]);
      end
      wait_idle(400, "t2_idle");
      chk("t2_count", q_out.size(), 48);
      chk("t2_done_cnt", done_cnt, 1);
      if (q_out.size() == 48) begin
         errs = 0;
         for (int i = 0; i < 48; i++)
            if (q_out[i] !== b1[i % 6][30*(i / 6) +: 30]) errs++;
         chk("t2_seq_errors", errs, 0);
      end

      // Ping-pong overlap with early third batch
      mode = 1'b0; rdy_mode = 0;
      q_out.delete(); done_cnt = 0;
      for (int r = 0; r < 7; r++) begin b1[r] = rand_row(); write_row(3'(r), b1[r]); end
      for (int r = 0; r < 7; r++) begin b2[r] = rand_row(); write_row(3'(r), b2[r]); end
      for (int r = 0; r < 3; r++) begin
         chk("t3_wr_ready_low", wr_ready, 1'b0);
         write_row(3'(r), rand_row());
      end
      wait_final_word("t3_final_word");
      chk("t3_wr_ready_before_accept", wr_ready, 1'b0);
      tick();
      chk("t3_wr_ready_rise", wr_ready, 1'b1);
      chk("t3_done", done, 1'b1);
      chk("t3_idle_gap", dout_valid, 1'b0);
      tick();
      chk("t3_batch2_valid", dout_valid, 1'b1);
      chk("t3_batch2_first", dout, b2[0][29:0]);
      wait_idle(300, "t3_idle");
      chk("t3_count", q_out.size(), 112);
      chk("t3_done_cnt", done_cnt, 2);
      if (q_out.size() == 112) begin
         errs = 0;
         for (int i = 0; i < 56; i++) begin
            if (q_out[i] !== b1[i % 7][30*(i / 7) +: 30]) errs++;
            if (q_out[56+i] !== b2[i % 7][30*(i / 7) +: 30]) errs++;
         end
         chk("t3_seq_errors", errs, 0);
      end

      // Out-of-order fill: completion is the row-6 write, not the final write
      ord = '{3, 0, 6, 1, 5, 2, 4};
      for (int i = 0; i < 7; i++) begin
         write_row(3'(ord[i]), rand_row());
         if (i < 2) chk("t4_no_early_start", dout_valid, 1'b0);
         if (i == 2) begin
            chk("t4_not_yet_at_row6_edge", dout_valid, 1'b0);
            $display("USAGE VIOLATION: out-of-order fill reaches row 6 before rows 1,5,2,4; batch closes at row 6 and later rows go to the other half");
         end
         if (i == 3) chk("t4_start_after_row6", dout_valid, 1'b1);
      end

      // Reset at word 20 with the other half partly written
      c = 0;
      while ((int'(rd_lane) * 7 + int'(rd_word)) != 20 && c < 100) begin tick(); c++; end
      if (c >= 100) timeout("t5_word20");
      rst = 1'b0;
      #1;
      chk("t5_dout_valid", dout_valid, 1'b0);
      chk("t5_dout", dout, 30'd0);
      chk("t5_rd_lane", rd_lane, 3'd0);
      chk("t5_rd_word", rd_word, 3'd0);
      chk("t5_last_word", last_word, 1'b0);
      chk("t5_done", done, 1'b0);
      chk("t5_wr_ready", wr_ready, 1'b1);
      tick(); tick();
      rst = 1'b1;
      tick();

      // Fresh batch to half 0, half 1 row 6 lands on its final accept edge
      q_out.delete(); done_cnt = 0;
      for (int r = 0; r < 7; r++) begin b1[r] = rand_row(); write_row(3'(r), b1[r]); end
      for (int r = 0; r < 6; r++) begin b2[r] = rand_row(); write_row(3'(r), b2[r]); end
      b2[6] = rand_row();
      wait_final_word("t6_final_word");
      write_row(3'd6, b2[6]);
      chk("t6_done", done, 1'b1);
      chk("t6_half0_free", wr_ready, 1'b1);
      chk("t6_gap", dout_valid, 1'b0);
      tick();
      chk("t6_half1_start", dout_valid, 1'b1);
      chk("t6_half1_first", dout, b2[0][29:0]);
      wait_idle(300, "t6_idle");
      chk("t6_count", q_out.size(), 112);
      chk("t6_done_cnt", done_cnt, 2);
      if (q_out.size() == 112) begin
         errs = 0;
         for (int i = 0; i < 56; i++) begin
            if (q_out[i] !== b1[i % 7][30*(i / 7) +: 30]) errs++;
            if (q_out[56+i] !== b2[i % 7][30*(i / 7) +: 30]) errs++;
         end
         chk("t6_seq_errors", errs, 0);
      end

      // Random backpressure, mode 1, two batches
      mode = 1'b1; rdy_mode = 2;
      done_cnt = 0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 6; r++) write_row(3'(r), rand_row());
      wait_idle(1000, "t7_idle");
      chk("t7_done_cnt", done_cnt, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
